// File: rtl/next_key.sv
// rtl/next_key.sv - one registered round of the 64-bit simplified-AES key schedule
module next_key #(
    parameter logic [3:0] RCON = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    input  logic [63:0] currentKey,
    output logic [63:0] nextKey,
    output logic        outValid
);

    logic [63:0] next_key_q, next_key_d;
    logic        out_valid_q, out_valid_d;

    logic [15:0] w0, w1, w2, w3;
    logic [15:0] w4, w5, w6, w7;
    logic [15:0] rot_w3;
    logic [15:0] sub_w3;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] s;
        case (n)
            4'h0:    s = 4'h9;
            4'h1:    s = 4'h4;
            4'h2:    s = 4'hA;
            4'h3:    s = 4'hB;
            4'h4:    s = 4'hD;
            4'h5:    s = 4'h1;
            4'h6:    s = 4'h8;
            4'h7:    s = 4'h5;
            4'h8:    s = 4'h6;
            4'h9:    s = 4'h2;
            4'hA:    s = 4'h0;
            4'hB:    s = 4'h3;
            4'hC:    s = 4'hC;
            4'hD:    s = 4'hE;
            4'hE:    s = 4'hF;
            default: s = 4'h7;
        endcase
        return s;
    endfunction

    function automatic logic [15:0] sub_nib(input logic [15:0] w);
        return {sbox(w[15:12]), sbox(w[11:8]), sbox(w[7:4]), sbox(w[3:0])};
    endfunction

    always_comb begin
        w0     = currentKey[63:48];
        w1     = currentKey[47:32];
        w2     = currentKey[31:16];
        w3     = currentKey[15:0];
        rot_w3 = {w3[11:0], w3[15:12]};
        sub_w3 = sub_nib(rot_w3);
        w4     = w0 ^ sub_w3 ^ {RCON, 12'h000};
        w5     = w1 ^ w4;
        w6     = w2 ^ w5;
        w7     = w3 ^ w6;
    end

    // Result register only loads on a valid input; the flag tracks inValid each cycle.
    always_comb begin
        next_key_d  = next_key_q;
        out_valid_d = inValid;
        if (inValid) begin
            next_key_d = {w4, w5, w6, w7};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_key_q  <= 64'h0;
            out_valid_q <= 1'b0;
        end else begin
            next_key_q  <= next_key_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign nextKey  = next_key_q;
    assign outValid = out_valid_q;

endmodule

// File: tb/tb_next_key.sv
// tb/tb_next_key.sv - directed self-checking bench for next_key
module tb_next_key;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [63:0] currentKey;
    logic [63:0] nextKey;
    logic        outValid;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                            4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};

    next_key #(.RCON(4'h1)) dut (
        .clk        (clk),
        .rst        (rst),
        .inValid    (inValid),
        .currentKey (currentKey),
        .nextKey    (nextKey),
        .outValid   (outValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [63:0] k);
        logic [15:0] a, b, c, d, t, e, f, g, h;
        a = k[63:48];
        b = k[47:32];
        c = k[31:16];
        d = k[15:0];
        t = {d[11:0], d[15:12]};
        for (int i = 0; i < 4; i++) begin
            t[i*4 +: 4] = sb[t[i*4 +: 4]];
        end
        e = a ^ t ^ 16'h1000;
        f = b ^ e;
        g = c ^ f;
        h = d ^ g;
        return {e, f, g, h};
    endfunction

    logic [63:0] exp_key;

    initial begin
        rst        = 1'b1;
        inValid    = 1'b1;
        currentKey = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        step();
        check("reset_key", nextKey, 64'h0);
        check("reset_valid", {63'h0, outValid}, 64'h0);

        rst        = 1'b0;
        currentKey = 64'h0;
        step();
        check("zero_key", nextKey, 64'h8999899989998999);
        check("zero_valid", {63'h0, outValid}, 64'h1);

        currentKey = 64'h123456789ABCDEF0;
        step();
        check("vec_key", nextKey, 64'hF5AAA3D2396EE79E);
        check("vec_valid", {63'h0, outValid}, 64'h1);

        currentKey = 64'h0;
        step();
        check("b2b_first", nextKey, 64'h8999899989998999);
        check("b2b_first_valid", {63'h0, outValid}, 64'h1);
        currentKey = 64'h123456789ABCDEF0;
        step();
        check("b2b_second", nextKey, 64'hF5AAA3D2396EE79E);
        check("b2b_second_valid", {63'h0, outValid}, 64'h1);

        inValid    = 1'b0;
        currentKey = 64'hDEADBEEFCAFED00D;
        step();
        check("hold_key", nextKey, 64'hF5AAA3D2396EE79E);
        check("hold_valid", {63'h0, outValid}, 64'h0);
        step();
        check("hold_key2", nextKey, 64'hF5AAA3D2396EE79E);

        inValid    = 1'b1;
        currentKey = 64'h123456789ABCDEF0;
        exp_key    = model(64'h123456789ABCDEF0);
        step();
        check("chain_0", nextKey, exp_key);
        for (int r = 1; r < 10; r++) begin
            currentKey = nextKey;
            exp_key    = model(exp_key);
            step();
            check($sformatf("chain_%0d", r), nextKey, exp_key);
            check($sformatf("chain_valid_%0d", r), {63'h0, outValid}, 64'h1);
        end

        rst        = 1'b1;
        inValid    = 1'b1;
        currentKey = 64'h123456789ABCDEF0;
        step();
        check("rst_prio_key", nextKey, 64'h0);
        check("rst_prio_valid", {63'h0, outValid}, 64'h0);

        rst        = 1'b0;
        currentKey = 64'h0;
        step();
        check("post_rst_key", nextKey, 64'h8999899989998999);
        check("post_rst_valid", {63'h0, outValid}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/next_key.md
Name: next_key

Overview:
- One round of the key schedule for the 64-bit simplified-AES datapath.
- Takes the current 64-bit round key and produces the next round key, registered with one-cycle latency.
- Sits between the key register/loader and the AddRoundKey stage. Each round's key is obtained by feeding `nextKey` back into `currentKey`.

Parameters:
- RCON, default 4'h1, round-constant nibble XORed into the most significant nibble of word w4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inValid  input  1  `currentKey` is valid this cycle; capture it and compute.
- currentKey  input  64  current round key.
- nextKey  output  64  registered next round key.
- outValid  output  1  `nextKey` holds the result of a captured input.

Behaviour:
- Word split: w0=currentKey[63:48], w1=[47:32], w2=[31:16], w3=[15:0]. Within a word, nibble n0 is the most significant.
- RotNib(w) = {n1,n2,n3,n0}, i.e. rotate left by 4 bits.
- SubNib(w): apply the S-box independently to each of the four nibbles.
- S-box, input 0..F -> output: 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- Key expansion:
  - w4 = w0 ^ SubNib(RotNib(w3)) ^ {RCON,12'h000}
  - w5 = w1 ^ w4
  - w6 = w2 ^ w5
  - w7 = w3 ^ w6
- Result: nextKey = {w4,w5,w6,w7}.
- Datapath is combinational from `currentKey` to a single output register.
- Latency: exactly 1 cycle. When `inValid`=1 at edge k, `nextKey` and `outValid`=1 are visible after edge k.
- If `inValid`=0 at an edge:
  - `nextKey` holds its previous value.
  - `outValid` goes to 0.
- No backpressure. `inValid` may be asserted every cycle, giving full throughput with one result per cycle.
- Reset:
  - When `rst`=1 at an edge: `nextKey`=64'h0 and `outValid`=0, regardless of `inValid`.
  - Reset has priority over capture.
  - Reset asserted mid-stream discards the pending computation.
- No X propagation: every S-box entry is defined and the output register always has a known value after reset.
- Pure bitwise logic; no carries, no overflow conditions.

Test Plan:
- Reset: hold rst=1 for 2 cycles with inValid=1, currentKey=64'hFFFF_FFFF_FFFF_FFFF -> nextKey=64'h0, outValid=0.
- Zero key: currentKey=64'h0000000000000000, inValid=1 -> one cycle later nextKey=64'h8999899989998999, outValid=1.
- Known vector: currentKey=64'h123456789ABCDEF0 -> nextKey=64'hF5AAA3D2396EE79E.
- Back-to-back: apply 64'h0 then 64'h123456789ABCDEF0 on consecutive cycles -> consecutive outputs 8999899989998999 then F5AAA3D2396EE79E, with outValid high both cycles.
- Hold: after a valid result, drop inValid and change currentKey to 64'hDEADBEEFCAFED00D -> nextKey unchanged, outValid=0.
- Chaining and reset-priority:
  - Feed nextKey back as currentKey for 10 rounds -> each output matches a software model using the S-box and RCON=1.
  - Assert rst with inValid=1 -> output clears to 0.
